// File: rtl/mips_mem_pkg.sv
// Shared types for the instruction/data RAM port arbiter. gnt_t is also
// consumed by the pipeline hazard unit.
package mips_mem_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_MEM_RD,
    GNT_MEM_WR
  } gnt_t;

  typedef enum logic [1:0] {
    IDLE,
    IF_RD,
    MEM_RD,
    MEM_WR
  } inflight_t;

  // The in-flight state is simply the grant type from the previous cycle.
  function automatic inflight_t gnt_to_inflight(input gnt_t g);
    case (g)
      GNT_IF:     return IF_RD;
      GNT_MEM_RD: return MEM_RD;
      GNT_MEM_WR: return MEM_WR;
      default:    return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/MEM stages, the arbiter and the RAM instance.
// master = pipeline + RAM side, slave = arbiter.
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic              ram_re;
  logic              ram_en;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_dout,
    input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
    input  stall_if, stall_mem, ram_addr, ram_din, ram_we, ram_re, ram_en
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_dout,
    output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
    output stall_if, stall_mem, ram_addr, ram_din, ram_we, ram_re, ram_en
  );

endinterface

// File: rtl/arb_starve_timer.sv
// Counts consecutive denied fetch cycles, saturating at MAX_WAIT; expired
// tells the arbiter to let fetch win for one cycle.
module arb_starve_timer #(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_en,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wait_en && (cnt_q != CW'(MAX_WAIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for state; reset is synchronous and sampled here.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data
// access: one grant per cycle, read data tagged back one cycle later.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  gnt_t              gnt;
  inflight_t         inflight_q;
  logic              starve_expired;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_din_d;

  arb_starve_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_timer (
    .clk     (clk),
    .reset   (reset),
    .wait_en (bus.stall_if),
    .clr     (!bus.if_req || bus.if_gnt),
    .expired (starve_expired)
  );

  // MEM normally wins; a starved fetch takes the port for exactly one cycle.
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (bus.if_req && (starve_expired || !bus.mem_req)) begin
        gnt = GNT_IF;
      end else if (bus.mem_req) begin
        gnt = bus.mem_we ? GNT_MEM_WR : GNT_MEM_RD;
      end
    end
  end

  always_comb begin
    ram_addr_d = '0;
    ram_din_d  = '0;
    case (gnt)
      GNT_IF:     ram_addr_d = bus.if_addr;
      GNT_MEM_RD: ram_addr_d = bus.mem_addr;
      GNT_MEM_WR: begin
        ram_addr_d = bus.mem_addr;
        ram_din_d  = bus.mem_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= IDLE;
    end else begin
      inflight_q <= gnt_to_inflight(gnt);
    end
  end

  assign bus.if_gnt    = (gnt == GNT_IF);
  assign bus.mem_gnt   = (gnt == GNT_MEM_RD) || (gnt == GNT_MEM_WR);
  assign bus.stall_if  = !reset && bus.if_req  && !bus.if_gnt;
  assign bus.stall_mem = !reset && bus.mem_req && !bus.mem_gnt;

  assign bus.ram_addr = ram_addr_d;
  assign bus.ram_din  = ram_din_d;
  assign bus.ram_re   = (gnt == GNT_IF) || (gnt == GNT_MEM_RD);
  assign bus.ram_we   = (gnt == GNT_MEM_WR);
  assign bus.ram_en   = !reset;

  // Reset also masks a read already in flight during the reset cycle itself.
  assign bus.if_rvalid  = !reset && (inflight_q == IF_RD);
  assign bus.mem_rvalid = !reset && (inflight_q == MEM_RD);
  assign bus.if_rdata   = bus.if_rvalid  ? bus.ram_dout : '0;
  assign bus.mem_rdata  = bus.mem_rvalid ? bus.ram_dout : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first single-port RAM
// model; table of per-cycle vectors plus hand-written reset/starvation runs.
module tb_mem_port_arbiter;

  localparam logic [31:0] R = 32'hC0DE_0000;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_port_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(5), .DATA_W(32), .MAX_WAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: contents R|addr, 1-cycle read latency, write-first.
  logic [31:0] ram [32];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 32; i++) ram[i] <= R | 32'(i);
      ram_loaded <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_we) begin
        ram[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout      <= bus.ram_din;
      end else if (bus.ram_re) begin
        bus.ram_dout <= ram[bus.ram_addr];
      end
    end
  end

  typedef struct {
    logic        if_req;
    logic [4:0]  if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        e_if_gnt;
    logic        e_mem_gnt;
    logic        e_stall_if;
    logic        e_stall_mem;
    logic        e_ram_we;
    logic        e_ram_re;
    logic [4:0]  e_ram_addr;
    logic [31:0] e_ram_din;
    logic        e_if_rvalid;
    logic [31:0] e_if_rdata;
    logic        e_mem_rvalid;
    logic [31:0] e_mem_rdata;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ir, input logic [4:0] ia,
                       input logic mr, input logic mw, input logic [4:0] ma,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.if_req    = ir;
    bus.if_addr   = ia;
    bus.mem_req   = mr;
    bus.mem_we    = mw;
    bus.mem_addr  = ma;
    bus.mem_wdata = wd;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " if_gnt"},     32'(bus.if_gnt),     32'd0);
    check({tag, " mem_gnt"},    32'(bus.mem_gnt),    32'd0);
    check({tag, " stall_if"},   32'(bus.stall_if),   32'd0);
    check({tag, " stall_mem"},  32'(bus.stall_mem),  32'd0);
    check({tag, " if_rvalid"},  32'(bus.if_rvalid),  32'd0);
    check({tag, " mem_rvalid"}, 32'(bus.mem_rvalid), 32'd0);
    check({tag, " ram_re"},     32'(bus.ram_re),     32'd0);
    check({tag, " ram_we"},     32'(bus.ram_we),     32'd0);
    check({tag, " ram_en"},     32'(bus.ram_en),     32'd0);
    check({tag, " ram_addr"},   32'(bus.ram_addr),   32'd0);
    check({tag, " ram_din"},    bus.ram_din,         32'd0);
    check({tag, " if_rdata"},   bus.if_rdata,        32'd0);
    check({tag, " mem_rdata"},  bus.mem_rdata,       32'd0);
  endtask

  initial begin
    //          if    ia     mem   we    ma     wdata           | ig    mg    sif   smem  we    re    addr   din             irv   irdata      mrv   mrdata
    // fetch stream 0,4,8 then idle
    vecs[0]  = '{1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0,          1'b0, 32'h0,      1'b0, 32'h0};
    vecs[1]  = '{1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 32'h0,          1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0,          1'b1, R | 32'd0,  1'b0, 32'h0};
    vecs[2]  = '{1'b1, 5'd8, 1'b0, 1'b0, 5'd0, 32'h0,          1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0,          1'b1, R | 32'd4,  1'b0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b1, R | 32'd8,  1'b0, 32'h0};
    // write 5 then read it back
    vecs[4]  = '{1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF,   1'b0, 32'h0,      1'b0, 32'h0};
    vecs[5]  = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0,          1'b0, 32'h0,      1'b0, 32'h0};
    vecs[6]  = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 32'h0,      1'b1, 32'hDEADBEEF};
    // both requesting for 5 cycles: MEM x3, IF once, MEM again
    vecs[7]  = '{1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'h0,          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0,          1'b0, 32'h0,      1'b0, 32'h0};
    vecs[8]  = '{1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'h0,          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0,          1'b0, 32'h0,      1'b1, R | 32'd2};
    vecs[9]  = '{1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'h0,          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0,          1'b0, 32'h0,      1'b1, R | 32'd2};
    vecs[10] = '{1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'h0,          1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0,          1'b0, 32'h0,      1'b1, R | 32'd2};
    vecs[11] = '{1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'h0,          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0,          1'b1, R | 32'd1,  1'b0, 32'h0};
    vecs[12] = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 32'h0,      1'b1, R | 32'd2};
    // write + fetch together, then read the written word back
    vecs[13] = '{1'b1, 5'd6, 1'b1, 1'b1, 5'd3, 32'h12345678,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 32'h12345678,   1'b0, 32'h0,      1'b0, 32'h0};
    vecs[14] = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 32'h0,      1'b0, 32'h0};
    vecs[15] = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd3, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0,          1'b0, 32'h0,      1'b0, 32'h0};
    vecs[16] = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,          1'b0, 32'h0,      1'b1, 32'h12345678};

    reset         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("por");

    for (int i = 0; i < 17; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      drive(1'b0, vecs[i].if_req, vecs[i].if_addr, vecs[i].mem_req, vecs[i].mem_we,
            vecs[i].mem_addr, vecs[i].mem_wdata);
      check({t, " if_gnt"},     32'(bus.if_gnt),     32'(vecs[i].e_if_gnt));
      check({t, " mem_gnt"},    32'(bus.mem_gnt),    32'(vecs[i].e_mem_gnt));
      check({t, " stall_if"},   32'(bus.stall_if),   32'(vecs[i].e_stall_if));
      check({t, " stall_mem"},  32'(bus.stall_mem),  32'(vecs[i].e_stall_mem));
      check({t, " ram_we"},     32'(bus.ram_we),     32'(vecs[i].e_ram_we));
      check({t, " ram_re"},     32'(bus.ram_re),     32'(vecs[i].e_ram_re));
      check({t, " ram_en"},     32'(bus.ram_en),     32'd1);
      check({t, " ram_addr"},   32'(bus.ram_addr),   32'(vecs[i].e_ram_addr));
      if (vecs[i].e_ram_we || !(vecs[i].e_if_gnt || vecs[i].e_mem_gnt))
        check({t, " ram_din"},  bus.ram_din,         vecs[i].e_ram_din);
      check({t, " if_rvalid"},  32'(bus.if_rvalid),  32'(vecs[i].e_if_rvalid));
      check({t, " if_rdata"},   bus.if_rdata,        vecs[i].e_if_rdata);
      check({t, " mem_rvalid"}, 32'(bus.mem_rvalid), 32'(vecs[i].e_mem_rvalid));
      check({t, " mem_rdata"},  bus.mem_rdata,       vecs[i].e_mem_rdata);
    end

    // Reset in the cycle after a fetch grant drops the pending read.
    drive(1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0);
    check("rst_a pre if_gnt", 32'(bus.if_gnt), 32'd1);
    drive(1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF);
    check_all_zero("rst_a during");
    drive(1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0);
    check("rst_a post if_gnt",    32'(bus.if_gnt),    32'd1);
    check("rst_a post if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rst_a post ram_en",    32'(bus.ram_en),    32'd1);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("rst_a data if_rvalid", 32'(bus.if_rvalid), 32'd1);
    check("rst_a data if_rdata",  bus.if_rdata,       R | 32'd7);

    // Starvation count built up before reset must not survive it.
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'h0);
      check($sformatf("rst_b c%0d stall_if", c), 32'(bus.stall_if), 32'd1);
    end
    drive(1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'h0);
    check("rst_b during mem_rvalid", 32'(bus.mem_rvalid), 32'd0);
    drive(1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 5'd2, 32'h0);
    check("rst_b post mem_gnt",  32'(bus.mem_gnt),  32'd1);
    check("rst_b post if_gnt",   32'(bus.if_gnt),   32'd0);
    check("rst_b post stall_if", 32'(bus.stall_if), 32'd1);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("rst_b tail mem_rdata", bus.mem_rdata, R | 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
